// File: rtl/clock_pkg.sv
// Shared types and limits for the BCD time-of-day core.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps MAX -> 00; wrap flags the increment that rolls over.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output bcd_t [1:0] value,
  output logic       wrap
);

  bcd_t [1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (inc) begin
      if (value_reg == MAX) begin
        value_reg <= '0;
      end else if (value_reg[0] == 4'd9) begin
        value_reg[0] <= 4'd0;
        value_reg[1] <= value_reg[1] + 4'd1;
      end else begin
        value_reg[0] <= value_reg[0] + 4'd1;
      end
    end
  end

  assign value = value_reg;
  assign wrap  = inc && (value_reg == MAX);

endmodule

// File: rtl/bcd_time_keeper.sv
// Time-of-day core: 1 Hz prescaler, BCD HH:MM:SS chain and a two-button set-mode FSM.
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TICK_W        = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output bcd_t [3:0]       digits,
  output logic [3:0]       blank,
  output bcd_t [1:0]       seconds,
  output logic             sec_tick,
  output logic [1:0]       mode
);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] BLINK_HALF = TICK_W'(TICKS_PER_SEC / 2);

  logic              btn_mode_q, btn_inc_q;
  logic              rise_mode, rise_inc;
  mode_t             mode_reg, mode_next;
  logic [TICK_W-1:0] presc_reg, blink_reg;
  logic              sec_tick_reg;
  logic              run, presc_wrap, leave_set_min;
  logic              sec_inc, min_inc, hour_inc;
  logic              sec_wrap, min_wrap, hour_wrap_unused;
  bcd_t [1:0]        sec_val, min_val, hour_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
    end
  end

  assign rise_mode = btn_mode & ~btn_mode_q;
  assign rise_inc  = btn_inc & ~btn_inc_q;

  always_ff @(posedge clk) begin
    if (rst) mode_reg <= RUN;
    else     mode_reg <= mode_next;
  end

  always_comb begin
    mode_next = mode_reg;
    if (rise_mode) begin
      case (mode_reg)
        RUN:      mode_next = SET_HOUR;
        SET_HOUR: mode_next = SET_MIN;
        default:  mode_next = RUN;
      endcase
    end
  end

  // Blank only in the second half of each blink period, so a digit is lit right after entry.
  always_comb begin
    blank = 4'b0000;
    if (blink_reg >= BLINK_HALF) begin
      case (mode_reg)
        SET_HOUR: blank = 4'b1100;
        SET_MIN:  blank = 4'b0011;
        default:  blank = 4'b0000;
      endcase
    end
  end

  assign run           = (mode_reg == RUN);
  assign presc_wrap    = run && (presc_reg == TICK_LAST);
  assign leave_set_min = (mode_reg == SET_MIN) && rise_mode;

  always_ff @(posedge clk) begin
    if (rst || leave_set_min) presc_reg <= '0;
    else if (run)             presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                    blink_reg <= '0;
    else if (mode_next != mode_reg || run) blink_reg <= '0;
    else                        blink_reg <= (blink_reg == TICK_LAST) ? '0 : blink_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sec_tick_reg <= 1'b0;
    else     sec_tick_reg <= presc_wrap;
  end

  // A simultaneous mode press wins; set-mode increments never carry into the next field.
  assign sec_inc  = presc_wrap;
  assign min_inc  = (run && sec_wrap) || ((mode_reg == SET_MIN) && rise_inc && !rise_mode);
  assign hour_inc = (run && min_wrap) || ((mode_reg == SET_HOUR) && rise_inc && !rise_mode);

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst || leave_set_min),
    .inc   (sec_inc),
    .value (sec_val),
    .wrap  (sec_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .value (min_val),
    .wrap  (min_wrap)
  );

  bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .inc   (hour_inc),
    .value (hour_val),
    .wrap  (hour_wrap_unused)
  );

  assign digits   = {hour_val, min_val};
  assign seconds  = sec_val;
  assign sec_tick = sec_tick_reg;
  assign mode     = mode_reg;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Bench for bcd_time_keeper: seconds-of-day reference model checked every cycle plus literal pins.
module tb_bcd_time_keeper;

  localparam int T = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn_mode = 1'b0;
  logic             btn_inc = 1'b0;
  logic [3:0][3:0]  digits;
  logic [3:0]       blank;
  logic [1:0][3:0]  seconds;
  logic             sec_tick;
  logic [1:0]       mode;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bcd_time_keeper #(.TICKS_PER_SEC(T), .TICK_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .digits   (digits),
    .blank    (blank),
    .seconds  (seconds),
    .sec_tick (sec_tick),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  // Reference: time kept as seconds-of-day, mode as 0/1/2, cycles spent in the current mode.
  int m_tod = 0, m_mode = 0, m_presc = 0, m_in_mode = 0, m_tick = 0;
  int m_pm = 0, m_pi = 0;

  always @(posedge clk) begin
    int rm, ri, nm, h, mi, s;
    if (rst) begin
      m_tod = 0; m_mode = 0; m_presc = 0; m_in_mode = 0; m_tick = 0; m_pm = 0; m_pi = 0;
    end else begin
      rm = (btn_mode && m_pm == 0) ? 1 : 0;
      ri = (btn_inc && m_pi == 0) ? 1 : 0;
      m_pm = btn_mode ? 1 : 0;
      m_pi = btn_inc ? 1 : 0;
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      m_tick = 0;
      nm = (rm != 0) ? (m_mode + 1) % 3 : m_mode;
      if (m_mode == 0) begin
        if (m_presc == T - 1) begin
          m_presc = 0; m_tick = 1; m_tod = (m_tod + 1) % 86400;
        end else m_presc = m_presc + 1;
      end else if (m_mode == 1) begin
        if (ri != 0 && rm == 0) m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
      end else begin
        if (ri != 0 && rm == 0) m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
        if (rm != 0) begin
          m_tod = m_tod - (m_tod % 60);
          m_presc = 0;
        end
      end
      m_in_mode = (nm != m_mode) ? 0 : m_in_mode + 1;
      m_mode = nm;
    end
  end

  function automatic logic [30:0] model_vec();
    int h, mi, s;
    logic [3:0] b;
    h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
    b = 4'b0000;
    if ((m_in_mode % T) >= T / 2) begin
      if (m_mode == 1) b = 4'b1100;
      if (m_mode == 2) b = 4'b0011;
    end
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
            4'(s / 10), 4'(s % 10), 1'(m_tick), 2'(m_mode), b};
  endfunction

  always @(posedge clk) begin
    logic [30:0] act, exp;
    #1;
    if (chk_en) begin
      act = {digits, seconds, sec_tick, mode, blank};
      exp = model_vec();
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got digits=%h sec=%h tick=%b mode=%0d blank=%b want %h",
                 $time, digits, seconds, sec_tick, mode, blank, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    @(negedge clk); btn_mode = 1'b1;
    @(negedge clk); btn_mode = 1'b0;
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      @(negedge clk); btn_inc = 1'b1;
      @(negedge clk); btn_inc = 1'b0;
    end
  endtask

  initial begin
    // 1: reset then first tick four cycles later
    cycles(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_digits", 32'(digits), 32'h0000);
    chk("reset_seconds", 32'(seconds), 32'h00);
    chk("reset_mode", 32'(mode), 32'd0);
    cycles(3);
    chk("tick_not_yet", 32'(sec_tick), 32'd0);
    cycles(1);
    chk("first_tick", 32'(sec_tick), 32'd1);
    chk("first_second", 32'(seconds), 32'h01);
    cycles(1);
    chk("tick_one_cycle", 32'(sec_tick), 32'd0);

    // 2: preload 23:59, run through midnight
    press_mode(); press_inc(23);
    press_mode(); press_inc(59);
    press_mode();
    chk("preload_digits", 32'(digits), 32'h2359);
    chk("preload_seconds", 32'(seconds), 32'h00);
    cycles(236);
    chk("pre_midnight", 32'({digits, seconds}), 32'h235959);
    cycles(4);
    chk("midnight", 32'({digits, seconds}), 32'h000000);
    chk("midnight_tick", 32'(sec_tick), 32'd1);

    // 3: hour setting, wrap and held button
    press_mode();
    chk("mode_set_hour", 32'(mode), 32'd1);
    press_inc(25);
    chk("hour_wrap", 32'(digits[3:2]), 32'h01);
    @(negedge clk); btn_inc = 1'b1;
    cycles(10); btn_inc = 1'b0;
    cycles(1);
    chk("hour_held", 32'(digits[3:2]), 32'h02);

    // 4: minute setting without carry, then restart counting
    press_mode();
    press_inc(61);
    chk("min_no_carry", 32'(digits), 32'h0201);
    press_mode();
    chk("back_run", 32'(mode), 32'd0);
    chk("run_sec_cleared", 32'(seconds), 32'h00);
    cycles(3);
    chk("restart_no_tick", 32'(sec_tick), 32'd0);
    cycles(1);
    chk("restart_tick", 32'({sec_tick, seconds}), 32'h101);

    // 5: simultaneous rise, blink pattern
    press_mode();
    @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
    @(negedge clk); btn_mode = 1'b0; btn_inc = 1'b0;
    chk("simul_mode", 32'(mode), 32'd2);
    chk("simul_hours", 32'(digits[3:2]), 32'h02);
    chk("blink_0", 32'(blank), 32'b0000);
    cycles(1); chk("blink_1", 32'(blank), 32'b0000);
    cycles(1); chk("blink_2", 32'(blank), 32'b0011);
    cycles(1); chk("blink_3", 32'(blank), 32'b0011);
    cycles(1); chk("blink_4", 32'(blank), 32'b0000);

    // 6: reset aborts a set at 12:34
    press_mode(); press_mode();
    press_inc(10);
    press_mode();
    press_inc(33);
    chk("at_1234", 32'({mode, digits}), 32'h21234);
    rst = 1'b1;
    cycles(1);
    chk("abort_reset", 32'({mode, blank, digits, seconds}), 32'h0000000);
    rst = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
